// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and default sizing for the round-robin register arbiter.
// State encoding is fixed: IDLE=0, GRANT=1.
package rr_reg_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/rr_reg_arbiter_pick.sv
// Round-robin priority search: first asserted req after last_owner, with wrap-around.
// Purely combinational; the arbiter holds all state.
module rr_pick #(
    parameter int N_REQ = rr_reg_arbiter_pkg::DEF_N_REQ,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_owner,
    output logic             valid,
    output logic [IW-1:0]    index
);

    int cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 0;
        // Walk from the farthest offset down so the nearest candidate wins.
        for (int off = N_REQ; off >= 1; off--) begin
            cand = (int'(last_owner) + off) % N_REQ;
            if (req[cand]) begin
                valid = 1'b1;
                index = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter guarding one shared register, with a bounded hold time
// so a busy owner is pre-empted when others are waiting.
module rr_reg_arbiter
    import rr_reg_arbiter_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       we,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                   busy,
    output logic [WIDTH-1:0]       q
);

    // state | meaning
    // IDLE  | no grant outstanding, gnt = 0, waiting for any req
    // GRANT | gnt[owner] high, owner may write q while it holds req

    localparam int IW = $clog2(N_REQ);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t           state;
    logic [IW-1:0]    last_owner;
    logic [HW-1:0]    hold_cnt;
    logic [N_REQ-1:0] pick_req;
    logic             pick_valid;
    logic [IW-1:0]    pick_index;
    logic [WIDTH-1:0] owner_wdata;
    logic             owner_req;
    logic             owner_we;

    // In GRANT the owner is masked so pick_valid means "someone else waits".
    assign pick_req = (state == GRANT) ? (req & ~gnt) : req;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req        (pick_req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .index      (pick_index)
    );

    always_comb begin
        owner_wdata = wdata[int'(owner)*WIDTH +: WIDTH];
        owner_req   = req[owner];
        owner_we    = we[owner];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            q          <= '0;
            hold_cnt   <= '0;
            last_owner <= IW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= GRANT;
                        busy       <= 1'b1;
                        gnt        <= ONE << pick_index;
                        owner      <= pick_index;
                        last_owner <= pick_index;
                        hold_cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (owner_req && owner_we) begin
                        q <= owner_wdata;
                    end
                    if (!owner_req || (hold_cnt == HOLD_LAST && pick_valid)) begin
                        if (pick_valid) begin
                            gnt        <= ONE << pick_index;
                            owner      <= pick_index;
                            last_owner <= pick_index;
                            hold_cnt   <= '0;
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            gnt      <= '0;
                            owner    <= '0;
                            hold_cnt <= '0;
                        end
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    gnt   <= '0;
                    owner <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/rr_reg_arbiter.md
RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the shared register width.
REQ-003 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum grant cycles while others wait.
REQ-004 The block SHALL have port clk  input  1  single clock, rising-edge.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port req  input  N_REQ  per-requester access request, held until served.
REQ-007 The block SHALL have port we  input  N_REQ  per-requester write enable, honoured only while granted.
REQ-008 The block SHALL have port wdata  input  N_REQ*WIDTH  packed write data, requester i at bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port gnt  output  N_REQ  one-hot registered grant, all zero when idle.
REQ-010 The block SHALL have port owner  output  clog2(N_REQ)  index of the current grantee, 0 when idle.
REQ-011 The block SHALL have port busy  output  1  high while in GRANT state.
REQ-012 The block SHALL have port q  output  WIDTH  contents of the shared register.

Function
REQ-013 The FSM SHALL have two states, IDLE and GRANT; gnt SHALL be nonzero only in GRANT.
REQ-014 In IDLE with any req high, the FSM SHALL go to GRANT next edge with gnt one-hot for the winner: 1-cycle latency from req sampled to gnt visible.
REQ-015 The winner SHALL be the first requester with req high, searching from (last_owner+1) mod N_REQ upward with wrap-around; last_owner resets to N_REQ-1, so requester 0 wins first.
REQ-016 In GRANT, when req[owner] drops and another req is high, the FSM SHALL grant the next round-robin winner on the same edge, with no idle cycle.
REQ-017 In GRANT, when req[owner] drops and no other req is high, the FSM SHALL return to IDLE and clear gnt.
REQ-018 A hold counter SHALL count grant cycles from 0. When it reaches MAX_HOLD-1 and another req is high, the owner SHALL be pre-empted to the next round-robin winner.
REQ-019 If no other requester waits, the hold counter SHALL saturate at MAX_HOLD-1 and the owner SHALL keep the grant.
REQ-020 The hold counter SHALL clear on every new grant.
REQ-021 q SHALL load wdata[owner] on an edge where state is GRANT and req[owner] and we[owner] are all high; otherwise q SHALL hold.
REQ-022 we and wdata from non-owners SHALL be ignored.
REQ-023 A write and a handover on the same edge SHALL both take effect: q takes the outgoing owner's data, and gnt moves to the new owner.
REQ-024 last_owner SHALL update to the index of each new grantee.

Reset
REQ-025 While reset is high at a rising edge, the next state SHALL be: state IDLE, gnt 0, owner 0, busy 0, q 0, hold counter 0, last_owner N_REQ-1.
REQ-026 Reset SHALL override any grant or write in progress, including reset during GRANT or on the cycle of a write.
REQ-027 Requests held through reset release SHALL be arbitrated normally starting the first cycle after reset deasserts.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=0, GRANT=1) and the default N_REQ, WIDTH and MAX_HOLD constants.
REQ-029 The round-robin priority search SHALL be one combinational sub-module, rr_pick (inputs req and last_owner; outputs valid and index).
REQ-030 All state elements SHALL be in rr_reg_arbiter.

Verification
REQ-031 Bench case: reset high 3 cycles with req=4'b1111 -> gnt=0, q=0 throughout; first cycle after release, gnt=4'b0001.
REQ-032 Bench case: req=4'b0100 alone, we[2]=1, wdata[2]=8'hA5 -> gnt=4'b0100 one cycle later, q=8'hA5 the cycle after that.
REQ-033 Bench case: req=4'b1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001, each held exactly MAX_HOLD=4 cycles.
REQ-034 Bench case: owner 1 drops req while req[3] is high -> gnt goes 0010 to 1000 on the next edge with no zero cycle.
REQ-035 Bench case: sole requester 0 holds 10 cycles -> gnt=0001 all 10 cycles; non-owner we[1]=1 with wdata=8'hFF -> q unchanged.
REQ-036 Bench case: reset asserted mid-grant with we high -> next cycle gnt=0, q=0, and the pending write is discarded.
